// File: rtl/dram_wbuf_pkg.sv
// ----------------------------------------------------------------------------
// dram_wbuf_pkg -- shared definitions for the DRAM store buffer.
//
// Holds the register-bus width macro, the entry-field widths, the buffered
// store entry layout and the controller state encoding. Imported by
// wbuf_fifo and dram_wbuf.
//
// Optional feature macro used by the importing files: DRAM_WBUF_FWD_EN.
// ----------------------------------------------------------------------------
`ifndef RegBus
`define RegBus 31:0
`endif

package dram_wbuf_pkg;

    localparam int ADDR_W  = 32;          // byte address width
    localparam int SEL_W   = 4;           // byte enables per word
    localparam int DATA_W  = 32;          // data word width
    localparam int WADDR_W = ADDR_W - 2;  // word address width (conflict match)

    // One buffered store.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// ----------------------------------------------------------------------------
// wbuf_fifo -- circular FIFO of buffered stores with a per-entry word-address
// match vector used to detect load/store conflicts.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          enqueue push_entry_i at the tail
//   push_entry_i    store entry {addr, sel, wdata}
//   pop_i           drop the head entry
//   head_o          oldest entry (valid when !empty_o)
//   full_o/empty_o  occupancy flags
//   match_addr_i    word address of a load
//   match_o         bit i set when live slot i holds match_addr_i
//   fwd_hit_o       (DRAM_WBUF_FWD_EN only) youngest match has all bytes
//   fwd_data_o      (DRAM_WBUF_FWD_EN only) data of the youngest match
//
// Optional feature: DRAM_WBUF_FWD_EN adds the youngest-match forwarding path.
// The caller must not push while full unless it pops in the same cycle, and
// must not pop while empty.
// ----------------------------------------------------------------------------
module wbuf_fifo
    import dram_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  entry_t             push_entry_i,
    input  logic               pop_i,
    output entry_t             head_o,
    output logic               full_o,
    output logic               empty_o,
    input  logic [WADDR_W-1:0] match_addr_i,
    output logic [DEPTH-1:0]   match_o
`ifdef DRAM_WBUF_FWD_EN
    ,
    output logic               fwd_hit_o,
    output logic [DATA_W-1:0]  fwd_data_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    entry_t           mem_q [DEPTH];
    logic [DEPTH-1:0] slot_live;

    // NOTE: combinational blocks assign a default to every output first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state is updated with non-blocking '<=' only; blocking
    // '=' is reserved for combinational logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam logic [PTR_W-1:0] SLOT = PTR_W'(i);
        assign slot_live[i] = ({1'b0, SLOT - rd_ptr_q} < count_q);
        assign match_o[i]   = slot_live[i] &&
                              (mem_q[i].addr[ADDR_W-1:2] == match_addr_i);
    end

`ifdef DRAM_WBUF_FWD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_found;

    // Walk oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        fwd_idx   = rd_ptr_q;
        fwd_found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_o[rd_ptr_q + PTR_W'(k)]) begin
                fwd_found = 1'b1;
                fwd_idx   = rd_ptr_q + PTR_W'(k);
            end
        end
    end

    assign fwd_hit_o  = fwd_found && (mem_q[fwd_idx].sel == '1);
    assign fwd_data_o = mem_q[fwd_idx].wdata;
`endif

endmodule

// File: rtl/dram_wbuf.sv
// ----------------------------------------------------------------------------
// dram_wbuf -- store buffer between the core's MEM stage and a single-port
// memory. Stores are posted into a FIFO and drained in the background; loads
// bypass pending drains unless they hit a buffered word, in which case they
// wait for that word to drain (or, with forwarding, take its data directly).
//
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   cpu_ce_i       core data access request
//   cpu_we_i       1 = store, 0 = load
//   cpu_sel_i      byte enables (all zero = no-op)
//   cpu_addr_i     byte address
//   cpu_wdata_i    store data
//   cpu_rdata_o    load data, valid while the load completes (RESP)
//   cpu_stall_o    pipeline stall request
//   mem_req_o      memory request, held until mem_ack_i
//   mem_we_o       1 for a drain write, 0 for a load read
//   mem_sel_o      memory byte enables
//   mem_addr_o     memory address
//   mem_wdata_o    memory write data
//   mem_ack_i      memory accepted request / read data valid
//   mem_rdata_i    memory read data
//
// Optional feature macro: DRAM_WBUF_FWD_EN -- a load hitting a full-word
// buffered store returns that store's data without a memory access.
// ----------------------------------------------------------------------------
module dram_wbuf
    import dram_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [SEL_W-1:0]  cpu_sel_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [`RegBus]    cpu_wdata_i,
    output logic [`RegBus]    cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [SEL_W-1:0]  mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [`RegBus]    mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [`RegBus]    mem_rdata_i
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [SEL_W-1:0]  mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              is_store, is_load;
    logic              do_push, do_pop;
    logic              fifo_full, fifo_empty;
    logic              conflict;
    logic [DEPTH-1:0]  match_vec;
    entry_t            push_entry, head;

    // An access with no byte enables is neither a load nor a store.
    assign is_store = cpu_ce_i &  cpu_we_i & (|cpu_sel_i);
    assign is_load  = cpu_ce_i & ~cpu_we_i & (|cpu_sel_i);

    // An ack is only meaningful in DRAIN/LOAD; a drain ack frees the head
    // entry, which lets a store waiting on a full buffer enqueue that cycle.
    assign do_pop   = (state_q == ST_DRAIN) & mem_ack_i;
    assign do_push  = is_store & (~fifo_full | do_pop);
    assign conflict = |match_vec;

    assign push_entry = '{addr: cpu_addr_i, sel: cpu_sel_i, wdata: cpu_wdata_i};

`ifdef DRAM_WBUF_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (do_push),
        .push_entry_i (push_entry),
        .pop_i        (do_pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .match_addr_i (cpu_addr_i[ADDR_W-1:2]),
        .match_o      (match_vec)
`ifdef DRAM_WBUF_FWD_EN
        ,
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data)
`endif
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        cpu_stall_o = is_store & fifo_full & ~do_pop;

        case (state_q)
            ST_IDLE: begin
                // A load is always held in IDLE: it is issuing, forwarding
                // or waiting on a conflicting entry.
                if (is_load) cpu_stall_o = 1'b1;
`ifdef DRAM_WBUF_FWD_EN
                if (is_load && conflict && fwd_hit) begin
                    state_d = ST_RESP;
                    rdata_d = fwd_data;
                end else
`endif
                if (is_load && !conflict) begin
                    // Loads take priority over background drains.
                    state_d     = ST_LOAD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_sel_d   = cpu_sel_i;
                    mem_addr_d  = cpu_addr_i;
                    mem_wdata_d = '0;
                end else if (!fifo_empty) begin
                    state_d     = ST_DRAIN;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_sel_d   = head.sel;
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.wdata;
                end
            end
            ST_DRAIN: begin
                if (is_load) cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (is_load) cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata_i;
                end
            end
            ST_RESP: begin
                // The load completes here: stall drops, rdata is valid.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_rdata_o = rdata_q;

endmodule
